// File: rtl/map_hub_pkg.sv
// Shared types and constants for the mapper hub: FSM states, channel-index width helper, default ID table.
// Pure declarations: no latency and no flow control of its own.
package map_hub_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LOOKUP    = 2'd1,
    WAIT_IDLE = 2'd2,
    BLANK     = 2'd3
  } state_t;

  function automatic int ch_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Current 16-slot mapper set, channel 0 in the low byte; ch14 is the no-mapper slot, ch15 unused.
  localparam logic [16*8-1:0] DEF_IDS = {
    8'd0,   8'd0,   8'd235, 8'd233, 8'd230, 8'd228, 8'd226, 8'd225,
    8'd218, 8'd207, 8'd190, 8'd163, 8'd162, 8'd111, 8'd46,  8'd30
  };

endpackage

// File: rtl/map_id_lookup.sv
// Parallel compare of a mapper index against the ID table with lowest-channel priority.
// Purely combinational, no handshake; a miss falls back to DEF_CH with hit low.
module map_id_lookup
  import map_hub_pkg::*;
#(
  parameter int                     N_CH   = 16,
  parameter int                     ID_W   = 8,
  parameter logic [N_CH*ID_W-1:0]   IDS    = '0,
  parameter int                     DEF_CH = 0
) (
  input  logic [ID_W-1:0]         idx,
  output logic                    hit,
  output logic [ch_w(N_CH)-1:0]   target
);

  localparam int CH_W = ch_w(N_CH);

  // Walk from the top down so the lowest matching channel is the last write.
  always_comb begin
    hit    = 1'b0;
    target = CH_W'(DEF_CH);
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (idx == IDS[k*ID_W +: ID_W]) begin
        hit    = 1'b1;
        target = CH_W'(k);
      end
    end
  end

endmodule

// File: rtl/map_hub_sw.sv
// Mapper output selector switched by req/done; same-channel switch completes 2 cycles after sel_req, otherwise 2+GAP_CYC once bus idle.
// Requests while busy are dropped; switches wait on bus_idle and blank map_out for GAP_CYC cycles.
module map_hub_sw
  import map_hub_pkg::*;
#(
  parameter int                     N_CH    = 16,
  parameter int                     ID_W    = 8,
  parameter int                     OUT_W   = 64,
  parameter logic [N_CH*ID_W-1:0]   IDS     = '0,
  parameter int                     DEF_CH  = 0,
  parameter int                     GAP_CYC = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ID_W-1:0]         map_idx,
  input  logic                    sel_req,
  input  logic                    bus_idle,
  input  logic [N_CH*OUT_W-1:0]   ch_in,
  output logic [OUT_W-1:0]        map_out,
  output logic [ch_w(N_CH)-1:0]   cur_ch,
  output logic                    hit,
  output logic                    sel_busy,
  output logic                    sw_done
);

  localparam int         CH_W     = ch_w(N_CH);
  localparam logic [3:0] GAP_INIT = 4'(GAP_CYC - 1);

  if (DEF_CH < 0 || DEF_CH >= N_CH) begin : g_bad_def_ch
    $error("map_hub_sw: DEF_CH outside 0..N_CH-1");
  end
  if (GAP_CYC < 1 || GAP_CYC > 15) begin : g_bad_gap
    $error("map_hub_sw: GAP_CYC outside 1..15");
  end
  if (N_CH < 2 || N_CH > 64) begin : g_bad_nch
    $error("map_hub_sw: N_CH outside 2..64");
  end

  state_t            state;
  logic [ID_W-1:0]   idx_q;
  logic [CH_W-1:0]   target_q;
  logic [3:0]        gap_cnt;
  logic              lk_hit;
  logic [CH_W-1:0]   lk_target;
  logic [OUT_W-1:0]  ch_arr [N_CH];

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign ch_arr[k] = ch_in[k*OUT_W +: OUT_W];
  end

  map_id_lookup #(
    .N_CH   (N_CH),
    .ID_W   (ID_W),
    .IDS    (IDS),
    .DEF_CH (DEF_CH)
  ) u_lookup (
    .idx    (idx_q),
    .hit    (lk_hit),
    .target (lk_target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      idx_q    <= '0;
      target_q <= CH_W'(DEF_CH);
      gap_cnt  <= '0;
      cur_ch   <= CH_W'(DEF_CH);
      hit      <= 1'b0;
      sel_busy <= 1'b0;
      sw_done  <= 1'b0;
    end else begin
      sw_done <= 1'b0;
      unique case (state)
        RUN: begin
          if (sel_req) begin
            idx_q    <= map_idx;
            state    <= LOOKUP;
            sel_busy <= 1'b1;
          end
        end
        LOOKUP: begin
          hit      <= lk_hit;
          target_q <= lk_target;
          if (lk_target == cur_ch) begin
            state    <= RUN;
            sel_busy <= 1'b0;
            sw_done  <= 1'b1;
          end else if (bus_idle) begin
            // Idle bus already: skip the wait so blanking starts right away.
            state   <= BLANK;
            gap_cnt <= GAP_INIT;
          end else begin
            state <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (bus_idle) begin
            state   <= BLANK;
            gap_cnt <= GAP_INIT;
          end
        end
        BLANK: begin
          if (gap_cnt == 4'd0) begin
            cur_ch   <= target_q;
            state    <= RUN;
            sel_busy <= 1'b0;
            sw_done  <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    map_out = ch_arr[cur_ch];
    if (!rst_n || state == BLANK) map_out = '0;
  end

endmodule

// File: tb/tb_map_hub_sw.sv
// Scoreboarded bench for map_hub_sw: expected {channel, hit} queued per accepted request, checked on sw_done.
// Directed timing checks cover blanking, bus_idle stall, dropped requests and reset mid-switch.
module tb_map_hub_sw;

  localparam int N_CH    = 16;
  localparam int ID_W    = 8;
  localparam int OUT_W   = 64;
  localparam int GAP_CYC = 2;
  localparam logic [N_CH*ID_W-1:0] TB_IDS = {
    8'd215, 8'd214, 8'd213, 8'd212, 8'd211, 8'd210, 8'd209, 8'd208,
    8'd46,  8'd206, 8'd205, 8'd163, 8'd203, 8'd46,  8'd201, 8'd30
  };

  typedef struct {
    int   ch;
    logic hit;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [ID_W-1:0]        map_idx = '0;
  logic                   sel_req = 1'b0;
  logic                   bus_idle = 1'b1;
  logic [N_CH*OUT_W-1:0]  ch_in;
  logic [OUT_W-1:0]       map_out;
  logic [3:0]             cur_ch;
  logic                   hit;
  logic                   sel_busy;
  logic                   sw_done;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  map_hub_sw #(
    .N_CH(N_CH), .ID_W(ID_W), .OUT_W(OUT_W), .IDS(TB_IDS), .DEF_CH(0), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .map_idx(map_idx), .sel_req(sel_req), .bus_idle(bus_idle),
    .ch_in(ch_in), .map_out(map_out), .cur_ch(cur_ch), .hit(hit), .sel_busy(sel_busy),
    .sw_done(sw_done)
  );

  always #5 clk = ~clk;

  function automatic logic [OUT_W-1:0] ch_val(input int k);
    return 64'hCAFE_0000_0000_0000 + 64'(k) * 64'h0000_0101_0001_0011;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [7:0] idx, input logic push, input int ch, input logic h);
    exp_t e;
    map_idx = idx;
    sel_req = 1'b1;
    if (push) begin
      e.ch  = ch;
      e.hit = h;
      sb.push_back(e);
    end
    tick();
    sel_req = 1'b0;
    map_idx = 8'd30;
  endtask

  task automatic wait_done(input int max, input string tag);
    int n;
    n = 0;
    while (!sw_done && n < max) begin
      tick();
      n++;
    end
    if (!sw_done) chk(tag, 64'd0, 64'd1);
  endtask

  always @(negedge clk) begin
    if (rst_n && sw_done) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_cur_ch", 64'(cur_ch), 64'(e.ch));
        chk("sb_hit", 64'(hit), 64'(e.hit));
        chk("sb_map_out", map_out, ch_val(e.ch));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int k = 0; k < N_CH; k++) ch_in[k*OUT_W +: OUT_W] = ch_val(k);

    // Reset
    #12;
    chk("rst_map_out", map_out, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_cur_ch", 64'(cur_ch), 64'd0);
    chk("rst_map_out_ch0", map_out, ch_val(0));
    chk("rst_hit", 64'(hit), 64'd0);
    chk("rst_busy", 64'(sel_busy), 64'd0);
    chk("rst_done", 64'(sw_done), 64'd0);

    // Switch to 163 (ch4) with idle bus: blank in cycles 2-3, done in cycle 4
    req(8'd163, 1'b1, 4, 1'b1);
    chk("sw4_c1_busy", 64'(sel_busy), 64'd1);
    chk("sw4_c1_out", map_out, ch_val(0));
    tick();
    chk("sw4_c2_blank", map_out, 64'd0);
    tick();
    chk("sw4_c3_blank", map_out, 64'd0);
    tick();
    chk("sw4_c4_done", 64'(sw_done), 64'd1);
    chk("sw4_c4_out", map_out, ch_val(4));
    tick();
    chk("sw4_c5_busy", 64'(sel_busy), 64'd0);

    // Same-channel request: lookup only, no blanking
    req(8'd163, 1'b1, 4, 1'b1);
    chk("same_c1_out", map_out, ch_val(4));
    tick();
    chk("same_c2_done", 64'(sw_done), 64'd1);
    chk("same_c2_out", map_out, ch_val(4));

    // Absent ID falls back to channel 0
    req(8'd99, 1'b1, 0, 1'b0);
    tick();
    chk("miss_c2_hit", 64'(hit), 64'd0);
    chk("miss_c2_blank", map_out, 64'd0);
    tick();
    tick();
    chk("miss_c4_done", 64'(sw_done), 64'd1);
    chk("miss_c4_out", map_out, ch_val(0));

    // Request in the sw_done cycle is accepted; duplicate 46 resolves to ch2
    req(8'd46, 1'b1, 2, 1'b1);
    wait_done(10, "dup_timeout");
    chk("dup_cur_ch", 64'(cur_ch), 64'd2);
    tick();

    // Bus busy: hold old channel, drop second request, finish GAP_CYC+1 after idle
    bus_idle = 1'b0;
    req(8'd163, 1'b1, 4, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("stall_out", map_out, ch_val(2));
      chk("stall_busy", 64'(sel_busy), 64'd1);
      sel_req = (i == 3);
      map_idx = 8'd30;
      tick();
    end
    sel_req = 1'b0;
    bus_idle = 1'b1;
    n = 0;
    while (!sw_done && n < 20) begin
      tick();
      n++;
      if (n == 1) begin
        chk("stall_blank", map_out, 64'd0);
        bus_idle = 1'b0;
      end
    end
    chk("stall_latency", 64'(n), 64'(GAP_CYC + 1));
    chk("stall_cur_ch", 64'(cur_ch), 64'd4);
    bus_idle = 1'b1;
    repeat (4) tick();
    chk("stall_no_extra", 64'(sel_busy), 64'd0);

    // Reset during BLANK discards the pending target
    req(8'd46, 1'b0, 2, 1'b1);
    tick();
    chk("rst_mid_blank", map_out, 64'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_cur_ch", 64'(cur_ch), 64'd0);
    chk("rst_mid_out", map_out, 64'd0);
    chk("rst_mid_busy", 64'(sel_busy), 64'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_done", 64'(sw_done), 64'd0);
    end
    chk("post_rst_out", map_out, ch_val(0));
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
